// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// This block arbitrates the single-port main memory between the
// instruction-cache line-fill path (I) and the data-cache access path (D).
// One requester owns the memory at a time. Ties are broken round-robin
// against the previous grant. An I grant runs a LINE_WORDS-beat line fill.
// A D grant runs one read or write beat. If any beat waits TIMEOUT cycles
// for mem_rdy, the transfer is aborted and err is pulsed with the done.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   i_req, i_addr       line-fill request and address (low bits ignored)
//   i_valid, i_data,    one-cycle fill-word strobe, word, and index in line
//   i_beat
//   i_done              one-cycle pulse when the fill finishes or aborts
//   d_req, d_we,        data access request, direction, address and
//   d_addr, d_wdata     write data
//   d_rdata, d_done     read data (valid with d_done); completion pulse
//   mem_req, mem_we,    memory beat request and write enable
//   mem_addr, mem_wdata memory word address and write data
//   mem_rdata, mem_rdy  memory read data; beat completion strobe
//   err                 pulses together with a done when the beat timed out
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned TO_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic                          i_req,
    input  logic [15:0]                   i_addr,
    output logic                          i_valid,
    output logic [15:0]                   i_data,
    output logic [$clog2(LINE_WORDS)-1:0] i_beat,
    output logic                          i_done,

    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [15:0]                   d_addr,
    input  logic [15:0]                   d_wdata,
    output logic [15:0]                   d_rdata,
    output logic                          d_done,

    output logic                          mem_req,
    output logic                          mem_we,
    output logic [15:0]                   mem_addr,
    output logic [15:0]                   mem_wdata,
    input  logic [15:0]                   mem_rdata,
    input  logic                          mem_rdy,

    output logic                          err
);

    localparam int unsigned BW = $clog2(LINE_WORDS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] IFILL = 2'd1;
    localparam logic [1:0] DACC  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [15:0]     LINE_MASK = 16'(LINE_WORDS - 1);
    localparam logic [BW-1:0]   LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);

    logic [1:0]      state;
    logic            last_d;     // previous grant went to D (reset: I)
    logic            cur_d;      // current transfer belongs to D
    logic            aborted;    // current transfer ended on a timeout
    logic [15:0]     lat_addr;   // line base (I) or word address (D)
    logic            lat_we;
    logic [15:0]     lat_wdata;
    logic [BW-1:0]   beat;
    logic [TO_W-1:0] tcnt;
    logic [TO_W-1:0] tcnt_inc;
    logic            pick_d;

    // D wins when alone, or on a tie when I had the previous grant.
    always_comb begin
        pick_d   = d_req && (!i_req || !last_d);
        tcnt_inc = tcnt + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            cur_d     <= 1'b0;
            aborted   <= 1'b0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            beat      <= '0;
            tcnt      <= '0;
            i_valid   <= 1'b0;
            i_data    <= '0;
            i_beat    <= '0;
            d_rdata   <= '0;
        end else begin
            i_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        cur_d   <= pick_d;
                        last_d  <= pick_d;
                        tcnt    <= '0;
                        beat    <= '0;
                        aborted <= 1'b0;
                        if (pick_d) begin
                            lat_addr  <= d_addr;
                            lat_we    <= d_we;
                            lat_wdata <= d_wdata;
                            state     <= DACC;
                        end else begin
                            lat_addr  <= i_addr & ~LINE_MASK;
                            lat_we    <= 1'b0;
                            lat_wdata <= '0;
                            state     <= IFILL;
                        end
                    end
                end

                IFILL: begin
                    if (mem_rdy) begin
                        tcnt    <= '0;
                        i_valid <= 1'b1;
                        i_data  <= mem_rdata;
                        i_beat  <= beat;
                        beat    <= beat + BW'(1);
                        if (beat == LAST_BEAT) begin
                            state <= DONE;
                        end
                    end else begin
                        tcnt <= tcnt_inc;
                        if (tcnt_inc == TO_LIMIT) begin
                            aborted <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end

                DACC: begin
                    if (mem_rdy) begin
                        tcnt <= '0;
                        if (!lat_we) begin
                            d_rdata <= mem_rdata;
                        end
                        state <= DONE;
                    end else begin
                        tcnt <= tcnt_inc;
                        if (tcnt_inc == TO_LIMIT) begin
                            aborted <= 1'b1;
                            if (!lat_we) begin
                                d_rdata <= 16'hFFFF;
                            end
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory-side and completion outputs decode directly from the state so
    // that an asynchronous reset drops mem_req in the same cycle.
    always_comb begin
        mem_req   = (state == IFILL) || (state == DACC);
        mem_we    = (state == DACC) && lat_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == IFILL) begin
            mem_addr = lat_addr + {{(16 - BW){1'b0}}, beat};
        end else if (state == DACC) begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
        end
        i_done = (state == DONE) && !cur_d;
        d_done = (state == DONE) && cur_d;
        err    = (state == DONE) && aborted;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_valid;
    logic [15:0] i_data;
    logic [1:0]  i_beat;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rdy = 1'b0;
    logic        err;

    int total = 0;
    int bad   = 0;
    int rcnt  = 0;

    // Observations gathered by xfer
    logic [15:0] ba[$];
    logic        bw[$];
    logic [15:0] bd[$];
    logic [1:0]  vb[$];
    logic [15:0] vd[$];
    int          req_cycles;
    logic        got_i, got_d, got_err, vat_done;
    logic [15:0] got_rdata;

    logic [71:0] outs;
    assign outs = {mem_req, mem_we, mem_addr, mem_wdata, i_valid, i_data,
                   i_beat, i_done, d_rdata, d_done, err};

    // Memory returns a recognisable function of the address.
    assign mem_rdata = mem_addr ^ 16'hA5A5;

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_WORDS(4), .TIMEOUT(255), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_data(i_data),
        .i_beat(i_beat), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .err(err)
    );

    // Runs cycles until a done pulse; mode selects mem_rdy behaviour:
    // 0 always, 1 every third cycle, 2 never, 3 random, 4 first k beats only.
    task automatic xfer(input int mode, input int k, input bit hold);
        int n;
        bit fin;
        ba.delete(); bw.delete(); bd.delete(); vb.delete(); vd.delete();
        req_cycles = 0; got_i = 0; got_d = 0; got_err = 0; vat_done = 0;
        got_rdata = '0;
        fin = 0;
        n = 0;
        while (!fin && n < 800) begin
            @(posedge clk); #1;
            n++; rcnt++;
            if (i_valid) begin vb.push_back(i_beat); vd.push_back(i_data); end
            if (i_done || d_done) begin
                fin = 1;
                got_i = i_done; got_d = d_done; got_err = err;
                got_rdata = d_rdata; vat_done = i_valid;
                if (!hold) begin
                    if (i_done) i_req = 0;
                    if (d_done) d_req = 0;
                end
            end
            if (mem_req) req_cycles++;
            case (mode)
                0: mem_rdy = 1'b1;
                1: mem_rdy = (rcnt % 3 == 0);
                2: mem_rdy = 1'b0;
                3: mem_rdy = 1'($urandom_range(0, 1));
                default: mem_rdy = (ba.size() < k);
            endcase
            if (mem_req && mem_rdy) begin
                ba.push_back(mem_addr); bw.push_back(mem_we); bd.push_back(mem_wdata);
            end
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL xfer_bound: no done within %0d cycles, required a done pulse", n);
        end
    endtask

    task automatic do_reset();
        i_req = 0; d_req = 0; mem_rdy = 0;
        rst = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (outs !== 72'd0) begin bad++; $display("FAIL reset_outs: got %h want 0", outs); end
        rst = 1;
        @(posedge clk); #1;
        total++;
        if (outs !== 72'd0) begin bad++; $display("FAIL idle_outs: got %h want 0", outs); end
        i_req = 1; i_addr = 16'h0042; mem_rdy = 0;
        @(posedge clk); #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0040) begin
            bad++; $display("FAIL fill_start: req=%b addr=%h want req=1 addr=0040", mem_req, mem_addr);
        end
        #3 rst = 0;
        #1;
        total++;
        if (mem_req !== 1'b0 || outs !== 72'd0) begin
            bad++; $display("FAIL async_reset: req=%b outs=%h want 0", mem_req, outs);
        end
        i_req = 0;
        @(posedge clk); #1;
        total++;
        if (i_done !== 1'b0 || outs !== 72'd0) begin
            bad++; $display("FAIL reset_no_done: outs=%h want 0", outs);
        end
        rst = 1;
        @(posedge clk); #1;
        total++;
        if (outs !== 72'd0) begin bad++; $display("FAIL post_reset: outs=%h want 0", outs); end
    endtask

    task automatic test_d_write();
        mem_rdy = 1;
        d_req = 1; d_we = 1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
        @(posedge clk); #1;   // grant edge
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, d_done} !== {1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0}) begin
            bad++;
            $display("FAIL dwr_beat: req=%b we=%b addr=%h data=%h done=%b want 1 1 1234 beef 0",
                     mem_req, mem_we, mem_addr, mem_wdata, d_done);
        end
        @(posedge clk); #1;
        total++;
        if ({d_done, mem_req, err, i_done} !== 4'b1000) begin
            bad++; $display("FAIL dwr_done: done=%b req=%b err=%b want done=1 req=0 err=0", d_done, mem_req, err);
        end
        d_req = 0;
        @(posedge clk); #1;
        total++;
        if ({d_done, mem_req} !== 2'b00) begin
            bad++; $display("FAIL dwr_idle: done=%b req=%b want 0 0", d_done, mem_req);
        end
        mem_rdy = 0;
    endtask

    task automatic test_ifill_wait();
        bit ok;
        logic [15:0] a;
        i_req = 1; i_addr = 16'h0203;
        xfer(1, 0, 0);
        ok = (ba.size() == 4) && (vb.size() == 4);
        for (int j = 0; j < 4 && ok; j++) begin
            a = 16'h0200 + 16'(j);
            if (ba[j] !== a || bw[j] !== 1'b0 || vb[j] !== 2'(j) || vd[j] !== (a ^ 16'hA5A5)) ok = 0;
        end
        total++;
        if (!ok) begin
            bad++; $display("FAIL ifill_beats: beats=%0d valids=%0d want 4 4 with addr 0200..0203", ba.size(), vb.size());
        end
        total++;
        if ({got_i, got_d, got_err, vat_done} !== 4'b1001) begin
            bad++; $display("FAIL ifill_done: i=%b d=%b err=%b valid_with_done=%b want 1 0 0 1", got_i, got_d, got_err, vat_done);
        end
        // Zero-wait fill of the top line: consecutive beats, 16-bit addresses.
        i_req = 1; i_addr = 16'hFFFE;
        xfer(0, 0, 0);
        ok = (ba.size() == 4) && (vb.size() == 4) && (req_cycles == 4);
        for (int j = 0; j < 4 && ok; j++) begin
            a = 16'hFFFC + 16'(j);
            if (ba[j] !== a || vd[j] !== (a ^ 16'hA5A5) || vb[j] !== 2'(j)) ok = 0;
        end
        total++;
        if (!ok || !vat_done || !got_i) begin
            bad++; $display("FAIL ifill_top: beats=%0d reqcyc=%0d want 4 4 at FFFC..FFFF", ba.size(), req_cycles);
        end
        mem_rdy = 0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_req = 1; i_addr = 16'h1000;
        d_req = 1; d_we = 0; d_addr = 16'h0050;
        xfer(0, 0, 1);
        total++;
        if (got_d !== 1'b1 || ba.size() != 1 || ba[0] !== 16'h0050 || got_rdata !== (16'h0050 ^ 16'hA5A5)) begin
            bad++; $display("FAIL tie_first: d=%b rdata=%h want d=1 rdata=%h", got_d, got_rdata, 16'h0050 ^ 16'hA5A5);
        end
        xfer(0, 0, 1);
        total++;
        if (got_i !== 1'b1 || ba.size() != 4 || ba[0] !== 16'h1000) begin
            bad++; $display("FAIL tie_second: i=%b beats=%0d want i=1 beats=4", got_i, ba.size());
        end
        xfer(0, 0, 0);
        total++;
        if (got_d !== 1'b1) begin bad++; $display("FAIL tie_third: d=%b want 1", got_d); end
        xfer(0, 0, 0);
        total++;
        if (got_i !== 1'b1) begin bad++; $display("FAIL tie_drain: i=%b want 1", got_i); end
        mem_rdy = 0;
    endtask

    task automatic test_timeout();
        d_req = 1; d_we = 0; d_addr = 16'h0777;
        xfer(2, 0, 0);
        total++;
        if (req_cycles != 255 || ba.size() != 0) begin
            bad++; $display("FAIL to_cycles: mem_req cycles=%0d want 255", req_cycles);
        end
        total++;
        if ({got_d, got_err, got_rdata} !== {1'b1, 1'b1, 16'hFFFF}) begin
            bad++; $display("FAIL to_done: d=%b err=%b rdata=%h want 1 1 ffff", got_d, got_err, got_rdata);
        end
        d_req = 1; d_we = 0; d_addr = 16'h0888;
        xfer(0, 0, 0);
        total++;
        if ({got_d, got_err, got_rdata} !== {1'b1, 1'b0, 16'h0888 ^ 16'hA5A5} || req_cycles != 1) begin
            bad++; $display("FAIL to_recover: d=%b err=%b rdata=%h reqcyc=%0d want 1 0 %h 1",
                            got_d, got_err, got_rdata, req_cycles, 16'h0888 ^ 16'hA5A5);
        end
        mem_rdy = 0;
    endtask

    task automatic test_fill_timeout();
        bit quiet;
        i_req = 1; i_addr = 16'h0310;
        xfer(4, 2, 0);
        total++;
        if (vb.size() != 2 || vb[0] !== 2'd0 || vb[1] !== 2'd1 || vd[1] !== (16'h0311 ^ 16'hA5A5)) begin
            bad++; $display("FAIL fto_valids: count=%0d want 2", vb.size());
        end
        total++;
        if ({got_i, got_err, vat_done} !== 3'b110 || req_cycles != 257) begin
            bad++; $display("FAIL fto_done: i=%b err=%b valid=%b reqcyc=%0d want 1 1 0 257",
                            got_i, got_err, vat_done, req_cycles);
        end
        quiet = 1;
        repeat (5) begin
            @(posedge clk); #1;
            if (mem_req || i_valid || i_done) quiet = 0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL fto_quiet: activity after abort, want none"); end
    endtask

    // Transaction-level model: arbitration by last winner, expected beats
    // and data derived from the request fields alone.
    task automatic test_random();
        bit pend_i, pend_d, m_last_d, exp_d, ok;
        int mode;
        logic [15:0] base, a;
        do_reset();
        pend_i = 0; pend_d = 0; m_last_d = 0;
        for (int t = 0; t < 40; t++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) begin
                pend_i = 1; i_addr = 16'($urandom); i_req = 1;
            end
            if (!pend_d && ($urandom_range(0, 1) == 1 || !pend_i)) begin
                pend_d = 1; d_we = 1'($urandom); d_addr = 16'($urandom);
                d_wdata = 16'($urandom); d_req = 1;
            end
            exp_d = pend_d && (!pend_i || !m_last_d);
            mode = ($urandom_range(0, 1) == 1) ? 0 : (($urandom_range(0, 1) == 1) ? 1 : 3);
            xfer(mode, 0, 0);
            total++;
            if (got_d !== exp_d || got_i !== !exp_d || got_err !== 1'b0) begin
                bad++; $display("FAIL rnd_grant[%0d]: d=%b i=%b err=%b want d=%b", t, got_d, got_i, got_err, exp_d);
            end
            ok = 1;
            if (exp_d) begin
                if (ba.size() != 1 || vb.size() != 0) ok = 0;
                else if (ba[0] !== d_addr || bw[0] !== d_we || (d_we && bd[0] !== d_wdata)) ok = 0;
                else if (!d_we && got_rdata !== (d_addr ^ 16'hA5A5)) ok = 0;
                pend_d = 0;
            end else begin
                base = i_addr & ~16'(L - 1);
                if (ba.size() != L || vb.size() != L || !vat_done) ok = 0;
                for (int j = 0; j < L && ok; j++) begin
                    a = base + 16'(j);
                    if (ba[j] !== a || bw[j] !== 1'b0 || vb[j] !== 2'(j) || vd[j] !== (a ^ 16'hA5A5)) ok = 0;
                end
                pend_i = 0;
            end
            total++;
            if (!ok) begin
                bad++; $display("FAIL rnd_data[%0d]: side_d=%b beats=%0d valids=%0d rdata=%h", t, exp_d, ba.size(), vb.size(), got_rdata);
            end
            m_last_d = exp_d;
        end
        mem_rdy = 0;
    endtask

    initial begin
        test_reset();
        test_d_write();
        test_ifill_wait();
        test_simultaneous();
        test_timeout();
        test_fill_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared backing-memory arbiter and sequencer sitting between the instruction-cache and data-cache miss paths and the single-port main memory. It grants the memory to one requester at a time with round-robin fairness, runs 4-word instruction line fills and single-word data reads/writes, and aborts any beat that exceeds a ready timeout. The processor clock domain drives it, and `rst` comes from the same reset source as the cache and processor.

## Interface
- `LINE_WORDS`, 4: words per instruction line fill; power of two, 2..8.
- `TIMEOUT`, 255: maximum cycles to wait for `mem_rdy` on one beat.
- `TO_W`, 8: timeout counter width; must satisfy 2^TO_W > TIMEOUT.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `i_req` in 1: instruction line-fill request; held high until `i_done`.
- `i_addr` in 16: fill address; low log2(LINE_WORDS) bits ignored.
- `i_valid` out 1: one-cycle pulse, `i_data`/`i_beat` valid.
- `i_data` out 16: fill word.
- `i_beat` out log2(LINE_WORDS): word index within the line.
- `i_done` out 1: one-cycle pulse, fill finished or aborted.
- `d_req` in 1: data access request; held high until `d_done`.
- `d_we` in 1: 1 = write, 0 = read; stable while `d_req` is high.
- `d_addr` in 16: data word address.
- `d_wdata` in 16: write data.
- `d_rdata` out 16: read data; valid while `d_done` is high.
- `d_done` out 1: one-cycle pulse, access finished or aborted.
- `mem_req` out 1: memory beat request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 16: memory word address.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data; valid in the cycle `mem_rdy` is high.
- `mem_rdy` in 1: beat accepted/completed when high while `mem_req` is high.
- `err` out 1: one-cycle pulse with `i_done`/`d_done` when the beat timed out.

## Operation
- **States:** IDLE, IFILL, DACC, DONE.
- **IDLE:**
  - If only one request is high, grant it.
  - If both are high, grant the side opposite to `last_grant`. `last_grant` resets to I, so D wins the first tie.
  - On a grant, latch the address. For I, latch `i_addr` with its low bits zeroed. For D, latch `d_addr`, `d_we` and `d_wdata`.
  - Update `last_grant`, then go to IFILL or DACC.
- **IFILL:**
  - Drive `mem_req=1`, `mem_we=0`, and `mem_addr` = line base + beat count.
  - On `mem_rdy`: register `mem_rdata` to `i_data`, pulse `i_valid` in the next cycle with `i_beat` = beat count, then increment the beat count.
  - After beat LINE_WORDS-1, go to DONE.
- **DACC:**
  - Drive `mem_req=1`, `mem_we=d_we`, `mem_addr`, and `mem_wdata`.
  - On `mem_rdy`: register `mem_rdata` into `d_rdata` (reads only), then go to DONE.
- **DONE:**
  - Pulse `i_done` or `d_done` for the granted side, then go to IDLE unconditionally.
  - The requester drops its request on seeing done, so IDLE never re-grants a stale request.
- **Timeout:**
  - The counter clears on grant and on every `mem_rdy`, and increments each busy cycle without `mem_rdy`.
  - When it reaches TIMEOUT: deassert `mem_req`, go to DONE, and pulse `err` with that side's done.
  - An aborted D read returns `d_rdata`=16'hFFFF. An aborted fill emits no further `i_valid`.
- `mem_req` is low in IDLE and DONE. Request inputs are ignored outside IDLE.

## Timing
- **Reset (`rst` low, immediate):** state IDLE and `last_grant`=I. Every output is 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `i_valid`, `i_data`, `i_beat`, `i_done`, `d_rdata`, `d_done`, `err`. The beat and timeout counters are also 0.
- **Reset mid-transfer:** `mem_req` drops asynchronously and no done is issued. Requesters re-request after reset.
- **Grant latency:** request seen high in IDLE at edge N → `mem_req` high from N+1.
- **D access with zero-wait memory** (`mem_rdy` high in the first `mem_req` cycle): `mem_req` cycle N+1, DONE with `d_done` in N+2, IDLE N+3. Minimum 3 cycles request-to-IDLE.
- **I fill with zero-wait memory:** LINE_WORDS consecutive `mem_req` cycles, with the address advancing every cycle. `i_valid` lags each `mem_rdy` by one cycle. The last `i_valid` coincides with `i_done`.
- `mem_addr` arithmetic is 16-bit modulo; a line at 16'hFFFC wraps nothing because it is aligned.
- Back-to-back: with both requests held, grants alternate D, I, D, I… with one DONE plus one IDLE cycle between transfers.

## Test plan
- **Reset defaults:** assert `rst`=0 mid-IFILL → `mem_req`=0 in the same cycle. After release, all outputs are 0 and the state is IDLE.
- **Zero-wait D write:** `d_req`=1, `d_we`=1, `d_addr`=16'h1234, `d_wdata`=16'hBEEF, `mem_rdy` tied 1 → one `mem_req` cycle with `mem_we`=1, address 16'h1234 and data 16'hBEEF, then `d_done` exactly two cycles after the grant edge.
- **I fill with wait states:** `i_addr`=16'h0203, `mem_rdy` high every 3rd cycle, memory returns addr^16'hA5A5 → addresses 16'h0200–0203 in order, four `i_valid` pulses with `i_beat` 0..3 and correct data, and `i_done` with the fourth.
- **Simultaneous requests after reset:** `i_req` and `d_req` rise together → D granted first and I second. With both held, the next grant is D again.
- **Timeout:** D read with `mem_rdy` stuck at 0 → `mem_req` high for exactly 255 cycles, then `d_done`=`err`=1 with `d_rdata`=16'hFFFF. Next request proceeds normally.
- **Timeout mid-fill:** `mem_rdy` stops after beat 1 → exactly two `i_valid` pulses, then `i_done` with `err`, and no further `mem_req`.
